mxn_scan: RTL and testbench
===========================

// Module: mxn_scan
// PURPOSE
//  Parametrised N:1 multiplexer with a registered channel select and a registered output.
//  - Select is loadable, or can step round-robin through the channels in scan mode.
//  - Generalises the fixed 6:1 bit selectors to any channel count and data width.
//  - Used where pixel and object datapaths sample one source per clock.
// PARAMETERS
//  CHANNELS  6   number of inputs, 1..2**SELW (need not be a power of 2)
//  WIDTH     1   data bits per channel
//  SELW      3   select width, must satisfy 2**SELW >= CHANNELS
// PORTS
//  clk       in   1               system clock, rising edge
//  resetl    in   1               asynchronous reset, active low
//  a         in   CHANNELS*WIDTH  channel data; channel k = a[k*WIDTH +: WIDTH]
//  sel_ld    in   1               load sel_in into the select register
//  sel_in    in   SELW            channel number to load
//  scan_en   in   1               enables step
//  step      in   1               advance the select by one (only when scan_en=1)
//  hold      in   1               freeze q and q_valid
//  q         out  WIDTH           registered selected data
//  q_valid   out  1               q was sampled with a stable select
//  cur_sel   out  SELW            current select register
//  wrap      out  1               1-cycle pulse: the select stepped from CHANNELS-1 to 0
//  sel_err   out  1               sticky: an out-of-range load was attempted
// BEHAVIOUR
//  Reset (resetl=0, asynchronous): all outputs are 0.
//  - cur_sel=0, q=0, q_valid=0, wrap=0, sel_err=0.
//  Select update at each clock edge (priority order):
//  1. sel_ld=1, sel_in<CHANNELS: cur_sel<=sel_in; sel_err<=0; counts as a change.
//  2. sel_ld=1, sel_in>=CHANNELS: cur_sel unchanged; sel_err<=1; not a change.
//     - A step asserted in the same cycle is discarded.
//  3. scan_en=1 and step=1: advance cur_sel; counts as a change.
//     - If cur_sel=CHANNELS-1, cur_sel<=0 and wrap<=1.
//     - Otherwise cur_sel<=cur_sel+1.
//  4. Otherwise: cur_sel holds.
//  - wrap is 0 on every edge without a wrapping step.
//  - A load always beats a step in the same cycle.
//  - A load of the current value counts as a change.
//  - step with scan_en=0 is ignored.
//  - CHANNELS=1: cur_sel stays 0, and every accepted step pulses wrap.
//  Output stage:
//  - hold=0: q<=a[cur_sel] using the pre-edge cur_sel; q_valid<=~change.
//  - hold=1: q and q_valid retain their values; select updates still occur.
//  Latency:
//  - Load or step at edge N -> q shows the new channel after edge N+1.
//  - q_valid is 0 after edge N and 1 after edge N+1, if no further change occurred.
//  - Data change on the selected channel -> q follows after 1 edge.
//  Reset asserted mid-scan clears everything immediately.
//  - After release, the first edge gives q=a[0], q_valid=1.
//  - A sel_err cleared by reset stays 0 until the next illegal load.
//  No combinational path from any input to any output.
// TESTING
//  1. Reset then 1 edge, a[0]=1, others 0 -> q=1, q_valid=1, cur_sel=0.
//  2. Load sel_in=4 at edge N (a[4]=1) -> cur_sel=4 after N.
//     -> q_valid=0 after N; q=1 and q_valid=1 after N+1.
//  3. scan_en=1, step held for 7 edges from cur_sel=0, CHANNELS=6 -> cur_sel 1..5,0,1.
//     -> wrap=1 only after edge 6.
//  4. Load sel_in=7 (CHANNELS=6) -> sel_err=1, cur_sel unchanged.
//     -> Then load 2 -> sel_err=0, cur_sel=2.
//  5. sel_ld=1 sel_in=3 with step=1 in the same cycle -> cur_sel=3, wrap=0.
//  6. hold=1 while a and the select change -> q and q_valid frozen.
//     -> Drop hold -> q tracks within 1 edge.
//     -> Pulse resetl low mid-scan -> all outputs 0 immediately.

Source files
------------

// File: rtl/mxn_scan_if.sv
// mxn_scan_if: channel data, select controls and registered results of the scanning N:1 mux
//   master: drives a, sel_ld, sel_in, scan_en, step, hold; samples q, q_valid, cur_sel, wrap, sel_err
//   slave : the mux side of the same signals
interface mxn_scan_if #(
  parameter int CHANNELS = 6,
  parameter int WIDTH    = 1,
  parameter int SELW     = 3
);
  logic [CHANNELS*WIDTH-1:0] a;
  logic                      sel_ld;
  logic [SELW-1:0]           sel_in;
  logic                      scan_en;
  logic                      step;
  logic                      hold;
  logic [WIDTH-1:0]          q;
  logic                      q_valid;
  logic [SELW-1:0]           cur_sel;
  logic                      wrap;
  logic                      sel_err;
  modport master (
    output a, sel_ld, sel_in, scan_en, step, hold,
    input  q, q_valid, cur_sel, wrap, sel_err
  );
  modport slave (
    input  a, sel_ld, sel_in, scan_en, step, hold,
    output q, q_valid, cur_sel, wrap, sel_err
  );
endinterface

// File: rtl/mxn_scan.sv
// mxn_scan: N:1 mux with a loadable / round-robin registered select and a registered output
//   clk    : rising-edge clock
//   resetl : asynchronous active-low reset, clears every output
//   bus    : mxn_scan_if slave (a, sel_ld, sel_in, scan_en, step, hold -> q, q_valid, cur_sel, wrap, sel_err)
module mxn_scan #(
  parameter int CHANNELS = 6,
  parameter int WIDTH    = 1,
  parameter int SELW     = 3
) (
  input logic         clk,
  input logic         resetl,
  mxn_scan_if.slave   bus
);
  logic [SELW-1:0]  sel_q, sel_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             valid_q, valid_d, wrap_q, wrap_d, err_q, err_d, change;
  always_comb begin
    sel_d  = sel_q;
    err_d  = err_q;
    wrap_d = 1'b0;
    change = 1'b0;
    if (bus.sel_ld) begin
      if (32'(bus.sel_in) < CHANNELS) begin
        sel_d  = bus.sel_in;
        err_d  = 1'b0;
        change = 1'b1;
      end else
        err_d = 1'b1;
    end else if (bus.scan_en && bus.step) begin
      change = 1'b1;
      wrap_d = sel_q == SELW'(CHANNELS - 1);
      sel_d  = wrap_d ? '0 : sel_q + 1'b1;
    end
    // output samples the channel chosen before this edge's select update
    q_d     = bus.hold ? q_q : bus.a[sel_q*WIDTH +: WIDTH];
    valid_d = bus.hold ? valid_q : ~change;
  end
  always_ff @(posedge clk or negedge resetl)
    if (!resetl) begin
      sel_q   <= '0;
      q_q     <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sel_q   <= sel_d;
      q_q     <= q_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  assign bus.q       = q_q;
  assign bus.q_valid = valid_q;
  assign bus.cur_sel = sel_q;
  assign bus.wrap    = wrap_q;
  assign bus.sel_err = err_q;
endmodule

// File: tb/tb_mxn_scan.sv
// tb_mxn_scan: directed and random stimulus against a cycle-level reference of the scanning mux
module tb_mxn_scan;
  localparam int CH = 6, W = 4, SW = 3;
  logic clk = 1'b0, resetl = 1'b0;
  int checks = 0, passed = 0, fails = 0, wraps = 0;
  int ch [CH];
  int m_sel = 0, m_q = 0, m_valid = 0, m_wrap = 0, m_err = 0;
  mxn_scan_if #(.CHANNELS(CH), .WIDTH(W), .SELW(SW)) bus ();
  mxn_scan #(.CHANNELS(CH), .WIDTH(W), .SELW(SW)) dut (.clk(clk), .resetl(resetl), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".cur_sel"}, int'(bus.cur_sel), m_sel);
    chk({tag, ".q"}, int'(bus.q), m_q);
    chk({tag, ".q_valid"}, int'(bus.q_valid), m_valid);
    chk({tag, ".wrap"}, int'(bus.wrap), m_wrap);
    chk({tag, ".sel_err"}, int'(bus.sel_err), m_err);
  endtask
  task automatic drive(input bit ld, input int sin, input bit sen, input bit st, input bit hd);
    bus.sel_ld = ld; bus.sel_in = SW'(sin); bus.scan_en = sen; bus.step = st; bus.hold = hd;
  endtask
  task automatic tick(input string tag);
    int n_sel;
    bit chg;
    for (int k = 0; k < CH; k++) bus.a[k*W +: W] = W'(ch[k]);
    n_sel = m_sel; chg = 0; m_wrap = 0;
    if (bus.sel_ld) begin
      if (int'(bus.sel_in) < CH) begin n_sel = int'(bus.sel_in); m_err = 0; chg = 1; end
      else m_err = 1;
    end else if (bus.scan_en && bus.step) begin
      chg = 1;
      m_wrap = (m_sel + 1 == CH) ? 1 : 0;
      n_sel = (m_sel + 1) % CH;
    end
    if (!bus.hold) begin m_q = ch[m_sel]; m_valid = chg ? 0 : 1; end
    m_sel = n_sel;
    @(posedge clk);
    #1;
    if (bus.wrap === 1'b1) wraps++;
    check_all(tag);
  endtask
  initial begin
    foreach (ch[k]) ch[k] = 0;
    ch[0] = 1;
    bus.a = '0;
    drive(0, 0, 0, 0, 0);
    #12;
    check_all("reset");
    @(negedge clk) resetl = 1'b1;
    tick("first_edge");
    chk("t1.q_is_1", int'(bus.q), 1);
    ch[4] = 1;
    drive(1, 4, 0, 0, 0); tick("load4");
    chk("t2.valid_low", int'(bus.q_valid), 0);
    drive(0, 0, 0, 0, 0); tick("load4_n1");
    chk("t2.q_ch4", int'(bus.q), 1);
    drive(1, 0, 0, 0, 0); tick("load0");
    drive(0, 0, 0, 0, 0); tick("settle0");
    wraps = 0;
    for (int i = 0; i < 7; i++) begin
      drive(0, 0, 1, 1, 0); tick("scan");
      chk("t3.wrap_at6", int'(bus.wrap), (i == 5) ? 1 : 0);
    end
    chk("t3.one_wrap", wraps, 1);
    drive(0, 0, 0, 1, 0); tick("step_no_en");
    drive(1, 7, 1, 1, 0); tick("bad_load");
    chk("t4.err", int'(bus.sel_err), 1);
    drive(1, 2, 0, 0, 0); tick("load2");
    chk("t4.sel2", int'(bus.cur_sel), 2);
    drive(1, 5, 0, 0, 0); tick("load5");
    drive(1, 3, 1, 1, 0); tick("load_beats_step");
    chk("t5.sel3", int'(bus.cur_sel), 3);
    chk("t5.nowrap", int'(bus.wrap), 0);
    drive(1, 3, 0, 0, 0); tick("reload_same");
    drive(0, 0, 0, 0, 0); tick("idle");
    for (int i = 0; i < 4; i++) begin
      foreach (ch[k]) ch[k] = int'($urandom_range(0, 15));
      drive(0, 0, 1, 1, 1); tick("hold");
    end
    drive(0, 0, 0, 0, 0); tick("unhold");
    chk("t6.q_tracks", int'(bus.q), ch[m_sel]);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) foreach (ch[k]) ch[k] = int'($urandom_range(0, 15));
      drive($urandom_range(0, 4) == 0, int'($urandom_range(0, 7)), $urandom_range(0, 2) != 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0);
      tick("rand");
    end
    drive(0, 0, 1, 1, 0);
    tick("pre_reset");
    #2 resetl = 1'b0;
    #1;
    m_sel = 0; m_q = 0; m_valid = 0; m_wrap = 0; m_err = 0;
    check_all("mid_reset");
    drive(0, 0, 0, 0, 0);
    @(negedge clk) resetl = 1'b1;
    tick("after_reset");
    chk("reset.q_a0", int'(bus.q), ch[0]);
    chk("reset.valid", int'(bus.q_valid), 1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
